// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder FSM state encodings and the bus
// address bytes used by the responder, the initiator and their benches.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ADDR  = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_SUB_ADDR  = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD_DATA   = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } sccb_state_e;

  localparam logic [7:0] SCCB_WR_ADDR = 8'h42;
  localparam logic [7:0] SCCB_RD_ADDR = 8'h43;

endpackage

// File: rtl/sccb_line_sync.sv
// Brings SCL/SDA into the clk domain and produces registered one-cycle
// strobes for SCL rise/fall and bus START/STOP, plus the SDA level that
// is aligned with those strobes.
module sccb_line_sync
  import sccb_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_rise_q;
  logic                   scl_fall_q;
  logic                   start_q;
  logic                   stop_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer chains, previous-level FFs and registered edge/condition strobes.
  // Idle bus level is high, so resetting to 1 avoids spurious strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      scl_rise_q <= scl_s & ~scl_prev_q;
      scl_fall_q <= ~scl_s & scl_prev_q;
      start_q    <= scl_s & scl_prev_q & ~sda_s & sda_prev_q;
      stop_q     <= scl_s & scl_prev_q & sda_s & ~sda_prev_q;
    end
  end

  assign sda_o      = sda_prev_q;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/sccb_responder.sv
// SCCB/I2C target with a 256x8 camera-style register file. Decodes the
// device address, sub-address and data bytes, ACKs and serialises read
// data on open-drain SDA, and offers a local read port and write strobe.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_tick,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic [3:0] status,
  input  logic [7:0] loc_addr,
  output logic [7:0] loc_data
);

  logic sda_s, rise_s, fall_s, start_s, stop_s;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_100MHz),
    .rst_i      (rst),
    .scl_i      (scl),
    .sda_i      (sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (rise_s),
    .scl_fall_o (fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  sccb_state_e state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rd_flag_q, rd_flag_d;
  logic [7:0]  sub_q, sub_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_tick_q, wr_tick_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic [7:0]  loc_data_q;
  logic        regs_we_s;
  logic [7:0]  rd_byte_s;
  logic [7:0]  regs_q [0:255];

  assign rd_byte_s = regs_q[sub_q];

  // Next-state and output decode; START/STOP override any SCL edge work.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rd_flag_d = rd_flag_q;
    sub_d     = sub_q;
    sda_oe_d  = sda_oe_q;
    wr_tick_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    regs_we_s = 1'b0;
    if (start_s) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_SUB_ADDR, ST_WR_DATA: begin
          if (rise_s && (bit_cnt_q < 4'd8)) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (fall_s && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            if (state_q == ST_DEV_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d   = ST_DEV_ACK;
                sda_oe_d  = 1'b1;
                rd_flag_d = shift_q[0];
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else if (state_q == ST_SUB_ADDR) begin
              state_d  = ST_SUB_ACK;
              sub_d    = shift_q;
              sda_oe_d = 1'b1;
            end else begin
              // Data byte complete: commit it and advance the pointer.
              state_d   = ST_WR_ACK;
              regs_we_s = 1'b1;
              wr_tick_d = 1'b1;
              wr_addr_d = sub_q;
              wr_data_d = shift_q;
              sub_d     = sub_q + 8'd1;
              sda_oe_d  = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_DEV_ACK: begin
          if (fall_s) begin
            if (rd_flag_q) begin
              // Releasing ACK and presenting the MSB share this SCL fall.
              state_d   = ST_RD_DATA;
              shift_d   = rd_byte_s;
              sda_oe_d  = ~rd_byte_s[7];
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = ST_SUB_ADDR;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_SUB_ACK, ST_WR_ACK: begin
          if (fall_s) begin
            state_d   = ST_WR_DATA;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end else begin
            state_d = state_q;
          end
        end
        ST_RD_DATA: begin
          if (fall_s) begin
            if (bit_cnt_q < 4'd8) begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              state_d   = ST_RD_ACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_RD_ACK: begin
          // bit_cnt marks that the initiator's ACK has been sampled.
          if (rise_s && (bit_cnt_q == 4'd0)) begin
            if (sda_s) begin
              state_d = ST_WAIT_STOP;
            end else begin
              sub_d     = sub_q + 8'd1;
              bit_cnt_d = 4'd1;
            end
          end else if (fall_s && (bit_cnt_q == 4'd1)) begin
            state_d   = ST_RD_DATA;
            shift_d   = rd_byte_s;
            sda_oe_d  = ~rd_byte_s[7];
            bit_cnt_d = 4'd1;
          end else begin
            state_d = state_q;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          state_d = state_q;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset; local read port.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      rd_flag_q  <= 1'b0;
      sub_q      <= 8'd0;
      sda_oe_q   <= 1'b0;
      wr_tick_q  <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      busy_q     <= 1'b0;
      loc_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rd_flag_q  <= rd_flag_d;
      sub_q      <= sub_d;
      sda_oe_q   <= sda_oe_d;
      wr_tick_q  <= wr_tick_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      loc_data_q <= regs_q[loc_addr];
    end
  end

  // Register file write port; contents survive reset by design.
  always_ff @(posedge clk_100MHz) begin
    if (regs_we_s && !rst) begin
      regs_q[sub_q] <= shift_q;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_tick  = wr_tick_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign status   = state_q;
  assign loc_data = loc_data_q;

endmodule
